cpu_instr_sequencer: RTL and testbench
======================================

// Module: cpu_instr_sequencer
// PURPOSE
//  Host-side initiator for the cpu block: stores a short program, then for each word drives
//  cpu_in/cpu_load, pulses cpu_s, waits for the cpu_w done handshake and returns cpu_out plus N/V/Z.
//  Sits between the testbench/host bus and the cpu; one cpu instruction is in flight at a time.
// PARAMETERS
//  DEPTH        16  program buffer entries (power of two)
//  AW           4   address width, log2(DEPTH)
//  TIMEOUT_CYC  64  max cycles waited per handshake phase (used only with SEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1     rising-edge clock
//  reset        in   1     asynchronous, active-low reset
//  prog_we      in   1     program-buffer write strobe (accepted only when busy=0)
//  prog_addr    in   AW    program write address
//  prog_data    in   16    instruction word to store
//  go           in   1     start run of len words from address 0 (sampled in IDLE only)
//  len          in   AW+1  words to execute; values >DEPTH are clamped to DEPTH
//  busy         out  1     run in progress
//  done         out  1     one-cycle pulse at end of run
//  cpu_in       out  16    instruction word to cpu
//  cpu_load     out  1     cpu instruction-register load strobe
//  cpu_s        out  1     cpu start strobe
//  cpu_out      in   16    cpu datapath result
//  cpu_N, cpu_V, cpu_Z in 1 cpu status flags
//  cpu_w        in   1     cpu waiting/idle (1 = ready for s)
//  res_valid    out  1     one-cycle pulse: result captured
//  res_idx      out  AW    program index of captured result
//  res_data     out  16    captured cpu_out
//  res_flags    out  3     captured {Z,N,V}
//  timeout_err  out  1     sticky watchdog error (constant 0 without SEQ_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset (async, reset=0): state=IDLE, pc=0; every output 0 incl. cpu_in, cpu_load, cpu_s,
//    res_*, busy, done, timeout_err. Program buffer contents not cleared. Mid-run reset aborts at once.
//  - States: IDLE -> LOAD -> START -> WBUSY -> WDONE -> (LOAD | FIN) ; FIN -> IDLE.
//  - IDLE: go=1 && len!=0 -> LOAD, busy=1, pc=0, cnt=min(len,DEPTH). go=1 && len==0 -> FIN (no cpu traffic).
//  - LOAD (1 cyc): cpu_in=mem[pc], cpu_load=1. cpu_in holds mem[pc] until next LOAD.
//  - START (1 cyc): cpu_s=1, only if cpu_w=1; else stay in START with cpu_s=0.
//  - WBUSY: wait for cpu_w=0 (cpu accepted); then -> WDONE.
//  - WDONE: on cpu_w=1: res_data<=cpu_out, res_flags<={cpu_Z,cpu_N,cpu_V}, res_idx<=pc,
//    res_valid=1 next cycle; pc+1; cnt-1; cnt reaching 0 -> FIN else LOAD.
//  - FIN (1 cyc): done=1, busy=0 next cycle -> IDLE. go during FIN/busy ignored.
//  - pc counts 0..cnt-1, never wraps within a run. prog_we while busy=1 ignored (no write).
//  - Min latency per word: LOAD+START+WBUSY+WDONE = 4 cycles plus cpu execute cycles.
//  - res_* hold last captured value between pulses.
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined: per-phase counter in START/WBUSY/WDONE; reaching TIMEOUT_CYC cycles
//    without the awaited cpu_w level sets timeout_err=1 (sticky until reset), aborts to FIN
//    (done pulses), no res_valid for that word. Counter clears on each phase entry.
//  SEQ_TIMEOUT_EN undefined: waits indefinitely; timeout_err tied 0; no counter logic.
// TESTING
//  1 reset=0 mid-WDONE -> all outputs 0 same cycle; after release, busy=0 and go restarts at pc 0.
//  2 prog 0x0000:16'hD105 (MOV R1,#5), go, len=1, cpu model echoes -> cpu_load 1 cyc with cpu_in=16'hD105,
//    cpu_s 1 cyc later, res_valid with res_idx=0, done pulse.
//  3 len=3, words 16'hD105,16'hD203,16'hA161 -> 3 res_valid pulses, idx 0,1,2, final res_data=16'h0008, flags=000.
//  4 len=0 -> done pulses 2 cycles after go, cpu_load/cpu_s never asserted; len=31 -> exactly 16 results.
//  5 prog_we to addr 2 while busy -> mem[2] unchanged on next run; go while busy -> ignored.
//  6 SEQ_TIMEOUT_EN, cpu_w stuck 0 -> timeout_err=1 after 64 cycles, done pulses, no res_valid.

Source files
------------

// File: rtl/cpu_instr_sequencer_if.sv
// cpu_instr_sequencer_if: host program/run bus plus cpu handshake bus for the instruction sequencer.
// master = sequencer side, slave = host and cpu side.
interface cpu_instr_sequencer_if #(parameter int AW = 4);
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic          go;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [15:0]   cpu_in;
    logic          cpu_load;
    logic          cpu_s;
    logic [15:0]   cpu_out;
    logic          cpu_n;
    logic          cpu_v;
    logic          cpu_z;
    logic          cpu_w;
    logic          res_valid;
    logic [AW-1:0] res_idx;
    logic [15:0]   res_data;
    logic [2:0]    res_flags;
    logic          timeout_err;
    modport master (
        input  prog_we, prog_addr, prog_data, go, len, cpu_out, cpu_n, cpu_v, cpu_z, cpu_w,
        output busy, done, cpu_in, cpu_load, cpu_s, res_valid, res_idx, res_data, res_flags, timeout_err
    );
    modport slave (
        output prog_we, prog_addr, prog_data, go, len, cpu_out, cpu_n, cpu_v, cpu_z, cpu_w,
        input  busy, done, cpu_in, cpu_load, cpu_s, res_valid, res_idx, res_data, res_flags, timeout_err
    );
endinterface

// File: rtl/cpu_instr_sequencer.sv
// cpu_instr_sequencer: stores a short program and feeds it word by word to the cpu, returning results.
// Optional per-phase watchdog enabled by defining SEQ_TIMEOUT_EN.
module cpu_instr_sequencer #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input logic                   clk,
    input logic                   rst_n,
    cpu_instr_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, START, WBUSY, WDONE, FIN} state_t;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    if (DEPTH != (1 << AW) || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("cpu_instr_sequencer: DEPTH must be 2**AW and TIMEOUT_CYC >= 2");
    end

    state_t        state_q, state_n, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [15:0]   cpu_in_q;
    logic          done_q, res_valid_q;
    logic [AW-1:0] res_idx_q;
    logic [15:0]   res_data_q;
    logic [2:0]    res_flags_q;
    logic [15:0]   mem [DEPTH];
    logic          capture, tmo_hit;

    assign capture = state_q == WDONE && bus.cpu_w;

    always_comb begin
        state_n = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.go) begin
                state_n = bus.len == '0 ? FIN : LOAD;
                pc_d    = '0;
                cnt_d   = bus.len > DEPTH_L ? DEPTH_L : bus.len;
            end
            LOAD:    state_n = START;
            START:   state_n = bus.cpu_w ? WBUSY : START;
            WBUSY:   state_n = bus.cpu_w ? WBUSY : WDONE;
            WDONE: if (bus.cpu_w) begin
                pc_d    = pc_q + 1'b1;
                cnt_d   = cnt_q - 1'b1;
                state_n = cnt_q == (AW+1)'(1) ? FIN : LOAD;
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        state_d = tmo_hit ? FIN : state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            cnt_q       <= '0;
            cpu_in_q    <= '0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            res_data_q  <= '0;
            res_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            done_q      <= state_q == FIN;
            res_valid_q <= capture;
            if (state_q == LOAD) cpu_in_q <= mem[pc_q];
            if (capture) begin
                res_idx_q   <= pc_q;
                res_data_q  <= bus.cpu_out;
                res_flags_q <= {bus.cpu_z, bus.cpu_n, bus.cpu_v};
            end
        end
    end

    // Buffer is not reset; writes only land while no run is in progress.
    always_ff @(posedge clk) begin
        if (bus.prog_we && state_q == IDLE) mem[bus.prog_addr] <= bus.prog_data;
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0] tmo_q;
    logic          tmo_err_q;
    assign tmo_hit = state_q inside {START, WBUSY, WDONE} && state_n == state_q &&
                     tmo_q == TW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_q     <= state_d != state_q ? '0 : tmo_q + 1'b1;
            tmo_err_q <= tmo_err_q | tmo_hit;
        end
    end
    assign bus.timeout_err = tmo_err_q;
`else
    assign tmo_hit         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.cpu_in    = state_q == LOAD ? mem[pc_q] : cpu_in_q;
    assign bus.cpu_load  = state_q == LOAD;
    assign bus.cpu_s     = state_q == START && bus.cpu_w;
    assign bus.busy      = state_q != IDLE;
    assign bus.done      = done_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_idx   = res_idx_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_flags = res_flags_q;
endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// tb_cpu_instr_sequencer: directed bench with a stand-in cpu (D=MOV rd,#imm; A=ADD rd,rd,r[ir[5:4]]).
module tb_cpu_instr_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0, n_pass = 0;
    int   n_load = 0, n_start = 0, n_res = 0, n_done = 0;
    logic [3:0]  idx_log [64];
    int   exec_cyc = 1;
    logic stuck = 1'b0;
    logic        w_q;
    int          ecnt;
    logic [15:0] ir, out_q;
    logic [15:0] regs [16];
    logic        z_q, n_q;

    cpu_instr_sequencer_if #(.AW(4)) bus ();
    cpu_instr_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    assign bus.cpu_w   = w_q & ~stuck;
    assign bus.cpu_out = out_q;
    assign bus.cpu_z   = z_q;
    assign bus.cpu_n   = n_q;
    assign bus.cpu_v   = 1'b0;

    function automatic logic [15:0] alu(input logic [15:0] i);
        return i[15:12] == 4'hD ? {8'h00, i[7:0]} : regs[i[11:8]] + regs[{2'b00, i[5:4]}];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q <= 1'b1; ecnt <= 0; ir <= '0; out_q <= '0; z_q <= 1'b0; n_q <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            if (bus.cpu_load) ir <= bus.cpu_in;
            if (bus.cpu_w && bus.cpu_s) begin
                w_q <= 1'b0; ecnt <= exec_cyc;
            end else if (!w_q) begin
                if (ecnt == 0) begin
                    w_q <= 1'b1;
                    out_q <= alu(ir);
                    regs[ir[11:8]] <= alu(ir);
                    z_q <= alu(ir) == 16'h0;
                    n_q <= alu(ir) >> 15 != 16'h0;
                end else ecnt <= ecnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.cpu_load) n_load++;
        if (bus.cpu_s) n_start++;
        if (bus.done) n_done++;
        if (bus.res_valid) begin
            idx_log[n_res % 64] = bus.res_idx;
            n_res++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic prog(input int a, input logic [15:0] d);
        @(negedge clk);
        bus.prog_we = 1'b1; bus.prog_addr = 4'(a); bus.prog_data = d;
        @(negedge clk);
        bus.prog_we = 1'b0;
    endtask

    task automatic start(input int l);
        @(negedge clk);
        bus.go = 1'b1; bus.len = 5'(l);
        @(negedge clk);
        bus.go = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int k = 0;
        while (!bus.done && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", bus.done, 1);
        @(negedge clk);
    endtask

    initial begin
        int b_load, b_start, b_res, b_done, k;
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0; bus.go = 1'b0; bus.len = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_outs", {bus.done, bus.cpu_load, bus.cpu_s, bus.res_valid, bus.timeout_err}, 0);
        chk("rst_cpu_in", bus.cpu_in, 0);
        chk("rst_res", {bus.res_idx, bus.res_data, bus.res_flags}, 0);
        rst_n = 1'b1;

        // single word run with exact handshake timing
        exec_cyc = 2;
        prog(0, 16'hD105);
        start(1);
        chk("t2_load", bus.cpu_load, 1);
        chk("t2_cpu_in", bus.cpu_in, 16'hD105);
        chk("t2_busy", bus.busy, 1);
        @(negedge clk);
        chk("t2_s", {bus.cpu_s, bus.cpu_load}, 2'b10);
        k = 0;
        while (!bus.res_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("t2_rv", bus.res_valid, 1);
        chk("t2_res", {bus.res_idx, bus.res_data, bus.res_flags}, {4'd0, 16'h0005, 3'b000});
        @(negedge clk);
        chk("t2_done", {bus.done, bus.busy, bus.res_valid}, 3'b100);
        chk("t2_hold", bus.cpu_in, 16'hD105);

        // three word program: 5 + 3
        exec_cyc = 1;
        prog(0, 16'hD105); prog(1, 16'hD203); prog(2, 16'hA161);
        b_res = n_res;
        start(3);
        wait_done(100);
        chk("t3_cnt", n_res - b_res, 3);
        chk("t3_idx", {idx_log[b_res % 64], idx_log[(b_res + 1) % 64], idx_log[(b_res + 2) % 64]}, 12'h012);
        chk("t3_res", {bus.res_data, bus.res_flags}, {16'h0008, 3'b000});

        // len=0: no cpu traffic, done two cycles after go
        b_load = n_load; b_start = n_start;
        start(0);
        chk("t4_n1", {bus.done, bus.busy}, 2'b01);
        @(negedge clk);
        chk("t4_n2", {bus.done, bus.busy}, 2'b10);
        @(negedge clk);
        chk("t4_traffic", (n_load - b_load) + (n_start - b_start), 0);

        // len=31 clamps to 16
        for (int i = 0; i < 16; i++) prog(i, {8'hD1, 8'(i)});
        b_res = n_res;
        start(31);
        wait_done(400);
        @(negedge clk);
        chk("t4_clamp", n_res - b_res, 16);
        chk("t4_last", {bus.res_idx, bus.res_data}, {4'd15, 16'h000F});

        // writes and go while busy are ignored
        exec_cyc = 6;
        b_done = n_done; b_res = n_res;
        start(3);
        bus.prog_we = 1'b1; bus.prog_addr = 4'd2; bus.prog_data = 16'hD1FF; bus.go = 1'b1; bus.len = 5'd5;
        @(negedge clk);
        bus.prog_we = 1'b0; bus.go = 1'b0;
        wait_done(200);
        repeat (3) @(negedge clk);
        chk("t5_idle", bus.busy, 0);
        chk("t5_runs", {n_done - b_done, n_res - b_res}, {32'd1, 32'd3});
        exec_cyc = 1;
        start(3);
        wait_done(100);
        chk("t5_mem2", {bus.res_idx, bus.res_data}, {4'd2, 16'h0002});

        // async reset while waiting in WDONE
        exec_cyc = 20;
        start(1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t1_busy", {bus.busy, bus.done, bus.cpu_load, bus.cpu_s, bus.res_valid, bus.timeout_err}, 0);
        chk("t1_cpu_in", bus.cpu_in, 0);
        chk("t1_res", {bus.res_idx, bus.res_data, bus.res_flags}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_idle", bus.busy, 0);
        exec_cyc = 1;
        b_load = n_load;
        start(1);
        wait_done(100);
        chk("t1_restart", {bus.res_idx, bus.res_data, bus.res_flags}, {4'd0, 16'h0000, 3'b100});
        chk("t1_loads", n_load - b_load, 1);

`ifdef SEQ_TIMEOUT_EN
        stuck = 1'b1;
        b_res = n_res;
        start(1);
        wait_done(150);
        chk("t6_err", bus.timeout_err, 1);
        chk("t6_nores", n_res - b_res, 0);
        stuck = 1'b0;
`else
        chk("t6_err_tied", bus.timeout_err, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
